mem_wb_pipe_reg: RTL and testbench

- Parametrised MEM/WB pipeline stage between data-memory access and register-file writeback.
- Replaces the fixed-width always-load register with a valid/ready handshake stage. A 2-entry skid buffer means the memory stage never sees a combinational ready path.
- Adds synchronous flush and a built-in writeback mux producing register-file write strobe and data.

---
 rtl/mem_wb_pkg.sv | 28 ++
 rtl/pipe_skid_buf.sv | 70 +++++++
 rtl/mem_wb_pipe_reg.sv | 76 +++++++
 tb/tb_mem_wb_pipe_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline stage: WB control bit positions,
// skid-buffer state encoding and the default-width payload layout.
package mem_wb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF     = 2;

  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_MEMTOREG_BIT = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Field order matches the concatenation used to feed the skid buffer.
  typedef struct packed {
    logic [CTRL_W_DEF-1:0]     ctrl;
    logic [DATA_W_DEF-1:0]     read_data;
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [REG_ADDR_W_DEF-1:0] write_reg;
  } mem_wb_payload_t;

  localparam int PAYLOAD_W_DEF = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready_o comes straight from a flop, so no combinational path from out_ready_i.
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output skid_state_e      state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and ready depends on flops only.
  skid_state_e      state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, pop;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = TWO;
        else if (!accept && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      unique case (state_q)
        EMPTY: if (accept) main_q <= in_data_i;
        ONE: begin
          if (accept && pop) main_q <= in_data_i;
          else if (accept)   skid_q <= in_data_i;
        end
        TWO:     if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign state_o     = state_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB stage: skid-buffered payload plus register-file writeback mux/strobe.
// Optional stall counter port enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl_wb,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl_wb,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic                  wb_we,
  output logic [DATA_W-1:0]     wb_data,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt,
`endif
  output skid_state_e           dbg_state
);

  localparam int PW = CTRL_W + 2 * DATA_W + REG_ADDR_W;

  logic [PW-1:0] in_payload, head;

  assign in_payload = {in_ctrl_wb, in_read_data, in_alu_result, in_write_reg};

  pipe_skid_buf #(.WIDTH(PW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (head),
    .state_o    (dbg_state)
  );

  assign out_ctrl_wb    = head[PW-1 -: CTRL_W];
  assign out_read_data  = head[2*DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign out_alu_result = head[DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign out_write_reg  = head[REG_ADDR_W-1:0];

  // Register 0 is hardwired, so a write to it is never strobed.
  assign wb_we   = out_valid & out_ready & out_ctrl_wb[CTRL_REGWRITE_BIT]
                 & (out_write_reg != '0);
  assign wb_data = out_ctrl_wb[CTRL_MEMTOREG_BIT] ? out_read_data : out_alu_result;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (out_valid && !out_ready && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed cases plus a random stream, all checked
// against a FIFO scoreboard of expected payloads.
module tb_mem_wb_pipe_reg;
  import mem_wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  mem_wb_payload_t cur = '0;

  logic                      in_ready, out_valid, wb_we;
  logic [CTRL_W_DEF-1:0]     out_ctrl_wb;
  logic [DATA_W_DEF-1:0]     out_read_data, out_alu_result, wb_data;
  logic [REG_ADDR_W_DEF-1:0] out_write_reg;
  skid_state_e               dbg_state;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0]               perf_stall_cnt;
  logic [31:0]               exp_perf = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic last_acc;
  logic [PAYLOAD_W_DEF-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl_wb    (cur.ctrl),
    .in_read_data  (cur.read_data),
    .in_alu_result (cur.alu_result),
    .in_write_reg  (cur.write_reg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl_wb   (out_ctrl_wb),
    .out_read_data (out_read_data),
    .out_alu_result(out_alu_result),
    .out_write_reg (out_write_reg),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
`ifdef MEM_WB_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] rg);
    in_valid       = v;
    cur.ctrl       = c;
    cur.read_data  = rd;
    cur.alu_result = alu;
    cur.write_reg  = rg;
  endtask

  // Called just after a falling edge with inputs settled; checks, updates the
  // scoreboard for the coming rising edge, then advances one cycle.
  task automatic tick();
    mem_wb_payload_t h;
    logic exp_ov, exp_rdy, exp_we, acc, pop;
    logic [1:0] exp_st;
    #1;
    exp_ov  = (exp_q.size() != 0);
    exp_rdy = (exp_q.size() != 2);
    exp_st  = 2'(exp_q.size());
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("state", 64'(dbg_state), 64'(exp_st));
    exp_we = 1'b0;
    if (exp_ov) begin
      h = mem_wb_payload_t'(exp_q[0]);
      chk("out_ctrl", 64'(out_ctrl_wb), 64'(h.ctrl));
      chk("out_rd", 64'(out_read_data), 64'(h.read_data));
      chk("out_alu", 64'(out_alu_result), 64'(h.alu_result));
      chk("out_reg", 64'(out_write_reg), 64'(h.write_reg));
      chk("wb_data", 64'(wb_data), 64'(h.ctrl[1] ? h.read_data : h.alu_result));
      exp_we = out_ready & h.ctrl[0] & (h.write_reg != 5'd0);
    end
    chk("wb_we", 64'(wb_we), 64'(exp_we));
`ifdef MEM_WB_PERF_CNT_EN
    chk("perf", 64'(perf_stall_cnt), 64'(exp_perf));
    if (exp_ov && !out_ready && exp_perf != 32'hFFFF_FFFF) exp_perf++;
`endif
    acc = in_valid & exp_rdy;
    pop = exp_ov & out_ready;
    last_acc = acc;
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(cur);
    if (flush) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic c_done;
    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_out_alu", 64'(out_alu_result), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    // Single ALU writeback, then load writeback
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h0, 32'h0000_1234, 5'd5); tick();
    drive(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h10, 5'd8); tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0); tick();
    tick();

    // Backpressure: A, B fill the buffer, C is held off until space opens
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'hA0A0, 32'hA, 5'd1); tick();
    drive(1'b1, 2'b11, 32'hB0B0, 32'hB, 5'd2); tick();
    drive(1'b1, 2'b01, 32'hC0C0, 32'hC, 5'd3); tick();
    tick();
    out_ready = 1'b1;
    c_done = 1'b0;
    for (int i = 0; i < 8 && !c_done; i++) begin
      tick();
      if (last_acc) begin
        c_done = 1'b1;
        in_valid = 1'b0;
      end
    end
    chk("c_accepted", 64'(c_done), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Flush with two held entries and a new input in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h1, 32'h1111, 5'd9); tick();
    drive(1'b1, 2'b01, 32'h2, 32'h2222, 5'd10); tick();
    drive(1'b1, 2'b01, 32'h3, 32'h3333, 5'd11); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    tick();

    // Flush coinciding with a pop: the head is still written back
    drive(1'b1, 2'b01, 32'h0, 32'h4444, 5'd12); tick();
    drive(1'b1, 2'b01, 32'h0, 32'h5555, 5'd13); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; tick();

    // Writes to register 0 are not strobed
    drive(1'b1, 2'b01, 32'h0, 32'h6666, 5'd0); tick();
    in_valid = 1'b0; tick();

    // Stall counting for 7 cycles with a held head
`ifdef MEM_WB_PERF_CNT_EN
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'h7777, 5'd14); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b1; tick(); tick();
`endif

    // Random stream
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), $urandom(),
            5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset pulse between clock edges with entries held
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'h8888, 5'd15); tick();
    drive(1'b1, 2'b01, 32'h0, 32'h9999, 5'd16); tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    exp_q.delete();
`ifdef MEM_WB_PERF_CNT_EN
    exp_perf = '0;
`endif
    #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b1;
    tick();
    drive(1'b1, 2'b11, 32'hCAFE_F00D, 32'h20, 5'd17); tick();
    in_valid = 1'b0; tick();

    // Counter saturation
`ifdef MEM_WB_PERF_CNT_EN
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0, 32'hAAAA, 5'd18); tick();
    in_valid = 1'b0;
    force dut.perf_q = 32'hFFFF_FFFE;
    #1 release dut.perf_q;
    exp_perf = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1; tick(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
